uart_rx: RTL and testbench

Serial UART receiver: the downstream stage of `uart_tx`, consuming its line output. It recovers 8N1+parity frames from an asynchronous serial line using 16x oversampling. Each received byte is presented on a single-entry valid/ready output register, with parity, framing and overrun status. It sits between the board RX pin and the byte-stream consumer (FIFO or command parser).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_os_tick.sv | 32 +++
 rtl/uart_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and helpers.
// Used by uart_rx now and uart_tx later.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int OS_DIV_DEF     = 54;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(
    input logic [UART_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_os_tick.sv
// uart_rx_os_tick: oversample tick divider.
// Single-cycle tick every OS_DIV clocks; clr holds phase at zero.
module uart_rx_os_tick
  import uart_pkg::*;
#(
  parameter int OS_DIV = OS_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clr && (cnt_q == LAST);

  // Divider count, wrapping at LAST and held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8-bit UART receiver with output buffer.
// Define UART_RX_PARITY_EN for start/8 data/even parity/stop frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OS_DIV     = OS_DIV_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DW  = UART_DATA_BITS;
  localparam int BCW = $clog2(DW);
  localparam int SCW = $clog2(OVERSAMPLE);

  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] MID_LO  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] MID     = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] MID_HI  = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DW - 1);

  rx_state_e state_q, state_d;

  logic           rx_m, rxs;
  logic           tick, os_clr;
  logic [SCW-1:0] sc_q, sc_nxt;
  logic           v0_q, v1_q, maj, decide;
  logic [BCW-1:0] bc_q;
  logic [DW-1:0]  sr_q;
  logic           shift, load;
  logic [7:0]     data_q;
  logic           valid_q, ferr_q, ovr_q;
`ifdef UART_RX_PARITY_EN
  logic           par_ld, par_bad_q, perr_q;
`endif

  // Two-flop synchronizer; idle-high reset avoids a false start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  assign os_clr = (state_q == IDLE) || (state_q == WAIT_HIGH);

  uart_rx_os_tick #(
    .OS_DIV(OS_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (os_clr),
    .tick (tick)
  );

  assign sc_nxt = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
  assign decide = tick && (sc_nxt == MID_HI);
  assign maj    = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);

  // Sample counter runs freely from the start edge, so each later
  // bit centre falls exactly one bit period after the previous one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
      v0_q <= 1'b1;
      v1_q <= 1'b1;
    end else if (os_clr) begin
      sc_q <= '0;
    end else if (tick) begin
      sc_q <= sc_nxt;
      if (sc_nxt == MID_LO) v0_q <= rxs;
      if (sc_nxt == MID)    v1_q <= rxs;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_d = state_q;
    shift   = 1'b0;
    load    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_ld  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (!rxs) state_d = START;
      end
      START: begin
        if (decide) state_d = maj ? IDLE : DATA;
      end
      DATA: begin
        if (decide) begin
          shift = 1'b1;
          if (bc_q == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (decide) begin
          par_ld  = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (decide) begin
          load    = 1'b1;
          state_d = maj ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc_q <= '0;
      sr_q <= '0;
    end else if (state_q == START) begin
      bc_q <= '0;
    end else if (shift) begin
      bc_q <= bc_q + 1'b1;
      sr_q <= {maj, sr_q[DW-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check against the assembled byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
    end else if (par_ld) begin
      par_bad_q <= maj ^ even_parity(sr_q);
    end
  end
`endif

  // Single-entry output buffer; a full, unaccepted buffer drops the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (load && (!valid_q || rx_ready)) begin
      data_q  <= sr_q;
      valid_q <= 1'b1;
      ferr_q  <= !maj;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= par_bad_q;
`endif
    end else if (load) begin
      ovr_q   <= 1'b1;
    end else begin
      ovr_q   <= 1'b0;
      if (valid_q && rx_ready) valid_q <= 1'b0;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus random frames for uart_rx.
// Expected values come from a frame-level model in this file.
module tb_uart_rx;

  localparam int OS_DIV = 8;
  localparam int OVS    = 16;
  localparam int BIT    = OS_DIV * OVS;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int passes = 0;
  int total  = 0;
  int ovr_cnt  = 0;
  int rise_cnt = 0;
  logic valid_d = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(
    .OS_DIV    (OS_DIV),
    .OVERSAMPLE(OVS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Event monitor: overrun cycles and rx_valid rising edges.
  always @(posedge clk) begin
    if (overrun === 1'b1) ovr_cnt++;
    if (rx_valid === 1'b1 && valid_d !== 1'b1) rise_cnt++;
    valid_d <= rx_valid;
  end

  // Model: parity error when data ones plus parity bit is odd.
  function automatic logic exp_perr(
    input logic [7:0] d,
    input logic       p
  );
    int ones;
    ones = $countones(d) + int'(p);
    return PAR ? ((ones % 2) != 0) : 1'b0;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic line(input logic b, input int nbits);
    rx = b;
    repeat (nbits * BIT) @(negedge clk);
  endtask

  task automatic send(
    input logic [7:0] d,
    input logic       p,
    input logic       stop,
    input int         extra_low
  );
    line(1'b0, 1);
    for (int i = 0; i < 8; i++) line(d[i], 1);
    if (PAR) line(p, 1);
    line(stop, 1);
    if (extra_low > 0) line(1'b0, extra_low);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 3 * BIT) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic check_frame(
    input string      tag,
    input logic [7:0] d,
    input logic       p,
    input logic       stop
  );
    wait_valid({tag, "_valid"});
    chk({tag, "_data"}, 32'(rx_data), 32'(d));
    chk({tag, "_perr"}, 32'(parity_err), 32'(exp_perr(d, p)));
    chk({tag, "_ferr"}, 32'(frame_err), 32'(!stop));
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk({tag, "_cleared"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    int r0, o0;
    logic [7:0] d;
    logic p;

    rx = 1'b1;
    rx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_perr", 32'(parity_err), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    line(1'b1, 1);

    send(8'hA5, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("a5", 8'hA5, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("a5_hold", 32'(rx_valid), 32'd1);
    accept("a5");

    send(8'h01, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("p01", 8'h01, 1'b0, 1'b1);
    accept("p01");

    r0 = rise_cnt;
    send(8'h3C, 1'b0, 1'b0, 2);
    check_frame("f3c", 8'h3C, 1'b0, 1'b0);
    accept("f3c");
    line(1'b0, 1);
    chk("f3c_no_second", 32'(rise_cnt - r0), 32'd1);
    line(1'b1, 1);
    send(8'h55, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("x55", 8'h55, 1'b0, 1'b1);
    accept("x55");

    r0 = rise_cnt;
    rx = 1'b0;
    repeat (4 * OS_DIV) @(negedge clk);
    line(1'b1, 2);
    chk("glitch_rise", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    send(8'h7E, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("x7e", 8'h7E, 1'b0, 1'b1);
    accept("x7e");

    o0 = ovr_cnt;
    send(8'h11, 1'b0, 1'b1, 0);
    send(8'h22, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("ovr", 8'h11, 1'b0, 1'b1);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    accept("ovr");

    send(8'h5A, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("pre_rst", 8'h5A, 1'b0, 1'b1);
    d = 8'hF0;
    line(1'b0, 1);
    for (int i = 0; i < 4; i++) line(d[i], 1);
    rx = d[4];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rx_valid), 32'd0);
    chk("mid_rst_data", 32'(rx_data), 32'd0);
    chk("mid_rst_perr", 32'(parity_err), 32'd0);
    chk("mid_rst_ferr", 32'(frame_err), 32'd0);
    chk("mid_rst_ovr", 32'(overrun), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = rise_cnt;
    line(1'b1, 2);
    chk("post_rst_quiet", 32'(rise_cnt - r0), 32'd0);
    send(8'h0F, 1'b0, 1'b1, 0);
    line(1'b1, 1);
    check_frame("x0f", 8'h0F, 1'b0, 1'b1);
    accept("x0f");

    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      p = 1'($urandom % 2);
      send(d, p, 1'b1, 0);
      rx = 1'b1;
      repeat ($urandom_range(1, BIT)) @(negedge clk);
      check_frame("rnd", d, p, 1'b1);
      accept("rnd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
